// File: rtl/iter_shift_unit.sv
// ---------------------------------------------------------------------------
// iter_shift_unit
//
// Multi-cycle shift execution unit for the ALU path. A variable-amount shift
// is performed by applying a single-position shift step once per clock, so a
// shift by N completes N+1 cycles after the request is accepted.
//
// Ports:
//   clk    in   1      single clock, all state updates on the rising edge
//   reset  in   1      synchronous, active-high reset
//   start  in   1      request a new shift; only honoured while busy=0
//   op     in   2      00=SLL, 01=SRL, 10=SRA (sign fill), 11=ROR
//   a      in   WIDTH  operand to shift
//   b      in   WIDTH  shift amount source; only b[SHW-1:0] is used
//   busy   out  1      high while an operation is in flight
//   done   out  1      one-cycle pulse, out was updated at this edge
//   out    out  WIDTH  result register, held until the next done
// ---------------------------------------------------------------------------
module iter_shift_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic [1:0]       op_q;

   logic             accept;
   logic             step;
   logic             finish;

   // Upper bits of b carry no meaning here: the amount is taken modulo 2^SHW.
   logic             unused_b_hi;
   assign unused_b_hi = ^b[WIDTH-1:SHW];

   // One-position shift step for the selected operation.
   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       sel);
      logic [WIDTH-1:0] r;
      case (sel)
         OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
         OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         OP_ROR:  r = {v[0], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      busy    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == '0) begin
               finish  = 1'b1;
               state_n = IDLE;
            end else begin
               step = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Operand capture, iteration and result registers. done is registered
   // from the completing edge, so it can only be high for a single cycle
   // per operation: the FSM has already left SHIFT when done is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         cnt  <= '0;
         op_q <= 2'b00;
         out  <= '0;
         done <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            acc  <= a;
            cnt  <= b[SHW-1:0];
            op_q <= op;
         end else if (step) begin
            acc <= shift_step(acc, op_q);
            cnt <= cnt - CNT_ONE;
         end
         if (finish) begin
            out <= acc;
         end
      end
   end

endmodule
